uart_fifo_regs: RTL and testbench

- Parametrised Avalon-MM register front-end for the UART core. Successor to the single-byte register block.
- Adds TX and RX FIFOs of configurable depth and a configurable data width.
- Adds RX threshold and error interrupts with W1C sticky status and TX/RX flush.
- Connects to the UART core via valid/ready streams; drives prescale.

---
 rtl/uart_fifo_regs.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_regs.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_regs.sv
// rtl/uart_fifo_regs.sv - Avalon-MM UART register front-end with TX/RX FIFOs, optional UART_RX_TIMEOUT_EN
module uart_fifo_regs #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] PRESCALE_RST = 16'd54
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            avl_mm_addr,
    input  logic                  avl_mm_read,
    output logic [31:0]           avl_mm_readdata,
    output logic [1:0]            avl_mm_response,
    input  logic                  avl_mm_write,
    input  logic [31:0]           avl_mm_writedata,
    input  logic [3:0]            avl_mm_byteenable,
    output logic                  avl_mm_waitrequest,
    output logic                  irq,
    output logic [DATA_WIDTH-1:0] data_tx,
    output logic                  data_tx_wr,
    input  logic                  data_tx_ack,
    input  logic [DATA_WIDTH-1:0] data_rx,
    input  logic                  data_rx_ready,
    output logic                  data_rx_ack,
    output logic [15:0]           prescale,
    input  logic                  tx_busy,
    input  logic                  rx_busy,
    input  logic                  rx_overrun_error,
    input  logic                  rx_frame_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];

    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [LW-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
    logic [15:0]   prescale_q, prescale_d;
    logic [3:0]    irq_en_q, irq_en_d;
    logic [7:0]    thresh_q, thresh_d;
    logic          ovr_q, ovr_d, frm_q, frm_d, txovf_q, txovf_d;
    logic          rd_pend_q, rd_pend_d, pop_pend_q, pop_pend_d;
    logic [31:0]   readdata_q, readdata_d;
    logic [1:0]    resp_q, resp_d;
    logic          irq_q, irq_d;
    logic          rx_ack_q, rx_ack_d;

    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, tx_push_req, tx_ovf_set, tx_flush;
    logic          rx_push, rx_pop, rx_flush;
    logic          rd_acc, wr_status, wr_ctrl;
    logic [3:0]    irq_stat;
    logic [31:0]   rd_mux;
    logic          tmo_cause;

`ifdef UART_RX_TIMEOUT_EN
    logic [15:0]   tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;
`endif

    logic unused_wdata;
    assign unused_wdata = ^{avl_mm_writedata[31:18], avl_mm_byteenable[3]};

    assign tx_empty    = (tx_lvl_q == '0);
    assign tx_full     = (tx_lvl_q == FULL_LVL);
    assign rx_empty    = (rx_lvl_q == '0);
    assign rx_full     = (rx_lvl_q == FULL_LVL);

    // A write wins over a read; a read stalls only in its first cycle
    assign rd_acc      = avl_mm_read & ~avl_mm_write & ~rd_pend_q;
    assign wr_status   = avl_mm_write & (avl_mm_addr == 5'd1);
    assign wr_ctrl     = avl_mm_write & (avl_mm_addr == 5'd2);

    assign tx_pop      = ~tx_empty & data_tx_ack;
    assign tx_push_req = avl_mm_write & (avl_mm_addr == 5'd0) & avl_mm_byteenable[0];
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;
    assign tx_flush    = wr_ctrl & avl_mm_byteenable[2] & avl_mm_writedata[16];
    assign rx_push     = data_rx_ready & ~rx_full;
    assign rx_pop      = pop_pend_q & ~rx_empty;
    assign rx_flush    = wr_ctrl & avl_mm_byteenable[2] & avl_mm_writedata[17];

`ifdef UART_RX_TIMEOUT_EN
    assign tmo_cause   = tmo_q;
`else
    assign tmo_cause   = 1'b0;
`endif

    assign irq_stat = {tmo_cause,
                       ovr_q | frm_q | txovf_q,
                       tx_empty,
                       (8'(rx_lvl_q) >= thresh_q) && (thresh_q != 8'd0)};

    assign avl_mm_waitrequest = rd_acc;
    assign avl_mm_readdata    = readdata_q;
    assign avl_mm_response    = resp_q;
    assign irq                = irq_q;
    assign data_tx            = tx_mem[tx_rp_q];
    assign data_tx_wr         = ~tx_empty;
    assign data_rx_ack        = rx_ack_q;
    assign prescale           = prescale_q;

    // Read data selection for the addressed register
    always_comb begin
        rd_mux = 32'd0;
        case (avl_mm_addr)
            5'd0: rd_mux = {rx_empty, {(31-DATA_WIDTH){1'b0}},
                            rx_empty ? {DATA_WIDTH{1'b0}} : rx_mem[rx_rp_q]};
            5'd1: rd_mux = {8'(tx_lvl_q), 8'(rx_lvl_q), 5'd0, txovf_q, frm_q, ovr_q,
                            2'd0, rx_busy, tx_busy, rx_empty, rx_full, tx_empty, tx_full};
            5'd2: rd_mux = {16'd0, prescale_q};
            5'd3: rd_mux = {28'd0, irq_en_q};
            5'd4: rd_mux = {28'd0, irq_stat};
            5'd5: rd_mux = {24'd0, thresh_q};
            default: rd_mux = 32'd0;
        endcase
    end

    // Next-state for FIFO pointers, registers, sticky status and read pipeline
    always_comb begin
        tx_wp_d    = tx_wp_q;
        tx_rp_d    = tx_rp_q;
        tx_lvl_d   = tx_lvl_q;
        rx_wp_d    = rx_wp_q;
        rx_rp_d    = rx_rp_q;
        rx_lvl_d   = rx_lvl_q;
        prescale_d = prescale_q;
        irq_en_d   = irq_en_q;
        thresh_d   = thresh_q;
        ovr_d      = ovr_q;
        frm_d      = frm_q;
        txovf_d    = txovf_q;
        readdata_d = readdata_q;
        resp_d     = resp_q;
        rd_pend_d  = 1'b0;
        pop_pend_d = 1'b0;

        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_lvl_d = '0;
        end else begin
            tx_wp_d  = tx_wp_q + AW'(tx_push);
            tx_rp_d  = tx_rp_q + AW'(tx_pop);
            tx_lvl_d = tx_lvl_q + LW'(tx_push) - LW'(tx_pop);
        end

        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_lvl_d = '0;
        end else begin
            rx_wp_d  = rx_wp_q + AW'(rx_push);
            rx_rp_d  = rx_rp_q + AW'(rx_pop);
            rx_lvl_d = rx_lvl_q + LW'(rx_push) - LW'(rx_pop);
        end

        // Clear-by-write first so a same-cycle event re-arms the sticky bit
        if (wr_status && avl_mm_byteenable[1]) begin
            if (avl_mm_writedata[8])  ovr_d   = 1'b0;
            if (avl_mm_writedata[9])  frm_d   = 1'b0;
            if (avl_mm_writedata[10]) txovf_d = 1'b0;
        end
        if (rx_overrun_error) ovr_d   = 1'b1;
        if (rx_frame_error)   frm_d   = 1'b1;
        if (tx_ovf_set)       txovf_d = 1'b1;

        if (wr_ctrl) begin
            if (avl_mm_byteenable[0]) prescale_d[7:0]  = avl_mm_writedata[7:0];
            if (avl_mm_byteenable[1]) prescale_d[15:8] = avl_mm_writedata[15:8];
        end
        if (avl_mm_write && avl_mm_addr == 5'd3 && avl_mm_byteenable[0]) begin
`ifdef UART_RX_TIMEOUT_EN
            irq_en_d = avl_mm_writedata[3:0];
`else
            irq_en_d = {1'b0, avl_mm_writedata[2:0]};
`endif
        end
        if (avl_mm_write && avl_mm_addr == 5'd5 && avl_mm_byteenable[0]) begin
            thresh_d = avl_mm_writedata[7:0];
        end

        if (rd_acc) begin
            rd_pend_d  = 1'b1;
            pop_pend_d = (avl_mm_addr == 5'd0) && !rx_empty;
            readdata_d = rd_mux;
            resp_d     = (avl_mm_addr >= 5'd8) ? 2'b10 : 2'b00;
        end
    end

    assign irq_d    = |(irq_en_q & irq_stat);
    assign rx_ack_d = (rx_lvl_d != FULL_LVL);

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= avl_mm_writedata[DATA_WIDTH-1:0];
        if (rx_push) rx_mem[rx_wp_q] <= data_rx;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_lvl_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_lvl_q   <= '0;
            prescale_q <= PRESCALE_RST;
            irq_en_q   <= '0;
            thresh_q   <= '0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            txovf_q    <= 1'b0;
            readdata_q <= '0;
            resp_q     <= 2'b00;
            rd_pend_q  <= 1'b0;
            pop_pend_q <= 1'b0;
            irq_q      <= 1'b0;
            rx_ack_q   <= 1'b0;
        end else begin
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_lvl_q   <= tx_lvl_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_lvl_q   <= rx_lvl_d;
            prescale_q <= prescale_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            ovr_q      <= ovr_d;
            frm_q      <= frm_d;
            txovf_q    <= txovf_d;
            readdata_q <= readdata_d;
            resp_q     <= resp_d;
            rd_pend_q  <= rd_pend_d;
            pop_pend_q <= pop_pend_d;
            irq_q      <= irq_d;
            rx_ack_q   <= rx_ack_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    // Idle counter: restarts on RX push or DATA read, saturates while data waits
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        if (rx_push || (rd_acc && avl_mm_addr == 5'd0)) begin
            tmo_cnt_d = 16'd0;
            tmo_d     = 1'b0;
        end else if (!rx_empty) begin
            if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
            if ({4'd0, tmo_cnt_q} >= {prescale_q, 4'd0}) tmo_d = 1'b1;
        end
    end

    // Timeout state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_regs.sv
// tb/tb_uart_fifo_regs.sv - Self-checking bench for uart_fifo_regs
module tb_uart_fifo_regs;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    addr;
    logic          read, write;
    logic [31:0]   readdata, wdata;
    logic [1:0]    response;
    logic [3:0]    be;
    logic          waitreq, irq;
    logic [DW-1:0] data_tx, data_rx;
    logic          data_tx_wr, data_tx_ack, data_rx_ready, data_rx_ack;
    logic [15:0]   prescale;
    logic          tx_busy, rx_busy, rx_overrun_error, rx_frame_error;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    logic          ovf_m;

    always #5 clk = ~clk;

    uart_fifo_regs #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_RST(16'd54)) dut (
        .clk(clk), .rst_n(rst_n),
        .avl_mm_addr(addr), .avl_mm_read(read), .avl_mm_readdata(readdata),
        .avl_mm_response(response), .avl_mm_write(write), .avl_mm_writedata(wdata),
        .avl_mm_byteenable(be), .avl_mm_waitrequest(waitreq), .irq(irq),
        .data_tx(data_tx), .data_tx_wr(data_tx_wr), .data_tx_ack(data_tx_ack),
        .data_rx(data_rx), .data_rx_ready(data_rx_ready), .data_rx_ack(data_rx_ack),
        .prescale(prescale), .tx_busy(tx_busy), .rx_busy(rx_busy),
        .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error)
    );

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; write = 1'b1;
        @(negedge clk);
        write = 1'b0; be = 4'd0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        addr = a; read = 1'b1; n = 0;
        @(negedge clk);
        while (waitreq && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (waitreq) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%0d waitrequest stuck at 1, required 0", a);
        end
        d = readdata; r = response; read = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        rst_n = 1'b0; read = 0; write = 0; addr = 0; wdata = 0; be = 0;
        data_tx_ack = 0; data_rx = 0; data_rx_ready = 0;
        tx_busy = 0; rx_busy = 0; rx_overrun_error = 0; rx_frame_error = 0;
        #22;
        checks++; if ({readdata, response, waitreq, irq, data_tx_wr, data_rx_ack} !== 38'd0) begin
            errors++; $display("FAIL reset_outputs got %h required 0", {readdata, response, waitreq, irq, data_tx_wr, data_rx_ack});
        end
        checks++; if (prescale !== 16'h0036) begin
            errors++; $display("FAIL reset_prescale got %h required 0036", prescale);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (data_rx_ack !== 1'b1) begin
            errors++; $display("FAIL rx_ack_after_reset got %b required 1", data_rx_ack);
        end
        bus_read(5'd1, d, r);
        checks++; if (d !== 32'h0000_000A || r !== 2'b00) begin
            errors++; $display("FAIL reset_status got %h/%b required 0000000a/00", d, r);
        end
        bus_read(5'd2, d, r);
        checks++; if (d !== 32'h0000_0036) begin
            errors++; $display("FAIL reset_ctrl got %h required 00000036", d);
        end
        tx_busy = 1'b1;
        bus_read(5'd1, d, r);
        tx_busy = 1'b0;
        checks++; if (d !== 32'h0000_001A) begin
            errors++; $display("FAIL status_tx_busy got %h required 0000001a", d);
        end
        bus_read(5'd9, d, r);
        checks++; if (d !== 32'd0 || r !== 2'b10) begin
            errors++; $display("FAIL unmapped_read got %h/%b required 0/10", d, r);
        end
        bus_read(5'd6, d, r);
        checks++; if (d !== 32'd0 || r !== 2'b00) begin
            errors++; $display("FAIL reserved_read got %h/%b required 0/00", d, r);
        end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_en;
        bus_write(5'd2, 32'h0000_1234, 4'b0011);
        bus_write(5'd2, 32'h0000_ABCD, 4'b0001);
        bus_read(5'd2, d, r);
        checks++; if (d !== 32'h0000_12CD || prescale !== 16'h12CD) begin
            errors++; $display("FAIL prescale_byteenable got %h/%h required 000012cd", d, prescale);
        end
        bus_write(5'd2, 32'h0000_0036, 4'b0011);
        bus_write(5'd3, 32'h0000_000F, 4'b0001);
        bus_read(5'd3, d, r);
`ifdef UART_RX_TIMEOUT_EN
        exp_en = 32'h0000_000F;
`else
        exp_en = 32'h0000_0007;
`endif
        checks++; if (d !== exp_en) begin
            errors++; $display("FAIL irq_en_rw got %h required %h", d, exp_en);
        end
        bus_write(5'd3, 32'h0, 4'b0001);
        bus_read(5'd4, d, r);
        checks++; if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL irq_stat_idle got %h required 00000002", d);
        end
    endtask

    task automatic test_tx_order;
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        data_tx_ack = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(5'd0, {24'd0, exp[i]}, 4'b0001);
        bus_read(5'd1, d, r);
        checks++; if (d[31:24] !== 8'd3) begin
            errors++; $display("FAIL tx_level3 got %0d required 3", d[31:24]);
        end
        @(negedge clk); data_tx_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (data_tx_wr !== 1'b1 || data_tx !== exp[i]) begin
                errors++; $display("FAIL tx_stream[%0d] got %b/%h required 1/%h", i, data_tx_wr, data_tx, exp[i]);
            end
            @(negedge clk);
        end
        checks++; if (data_tx_wr !== 1'b0) begin
            errors++; $display("FAIL tx_drained got %b required 0", data_tx_wr);
        end
        data_tx_ack = 1'b0;
    endtask

    task automatic test_rx_fill;
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); data_rx = DW'(i); data_rx_ready = 1'b1;
        end
        @(negedge clk); data_rx = 8'hEE;
        @(negedge clk); data_rx_ready = 1'b0;
        checks++; if (data_rx_ack !== 1'b0) begin
            errors++; $display("FAIL rx_ack_full got %b required 0", data_rx_ack);
        end
        bus_read(5'd1, d, r);
        checks++; if (d[2] !== 1'b1 || d[23:16] !== 8'(DEPTH)) begin
            errors++; $display("FAIL rx_full_status got %h required rx_full with level %0d", d, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(5'd0, d, r);
            checks++; if (d !== 32'(i)) begin
                errors++; $display("FAIL rx_read[%0d] got %h required %h", i, d, 32'(i));
            end
        end
        bus_read(5'd0, d, r);
        checks++; if (d !== 32'h8000_0000) begin
            errors++; $display("FAIL rx_read_empty got %h required 80000000", d);
        end
    endtask

    task automatic test_thresh_irq;
        logic [31:0] d;
        logic [1:0]  r;
        bus_write(5'd5, 32'd4, 4'b0001);
        bus_write(5'd3, 32'd1, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); data_rx = DW'(8'h50 + i); data_rx_ready = 1'b1;
        end
        @(negedge clk); data_rx_ready = 1'b0;
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL thresh_irq_early got %b required 0", irq);
        end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin
            errors++; $display("FAIL thresh_irq_rise got %b required 1", irq);
        end
        bus_read(5'd0, d, r);
        checks++; if (d !== 32'h50) begin
            errors++; $display("FAIL thresh_read got %h required 00000050", d);
        end
        @(negedge clk); @(negedge clk);
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL thresh_irq_fall got %b required 0", irq);
        end
        bus_write(5'd3, 32'd0, 4'b0001);
        bus_write(5'd5, 32'd0, 4'b0001);
        bus_write(5'd2, 32'h0002_0000, 4'b0100);
        bus_read(5'd1, d, r);
        checks++; if (d[23:16] !== 8'd0 || d[3] !== 1'b1) begin
            errors++; $display("FAIL rx_flush got %h required rx empty level 0", d);
        end
    endtask

    task automatic test_frame_err;
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk); rx_frame_error = 1'b1;
        @(negedge clk); rx_frame_error = 1'b0;
        bus_write(5'd3, 32'd4, 4'b0001);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin
            errors++; $display("FAIL frame_irq got %b required 1", irq);
        end
        bus_read(5'd1, d, r);
        checks++; if (d[10:8] !== 3'b010) begin
            errors++; $display("FAIL frame_sticky got %b required 010", d[10:8]);
        end
        bus_write(5'd1, 32'h200, 4'b0010);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL frame_irq_clear got %b required 0", irq);
        end
        bus_read(5'd1, d, r);
        checks++; if (d[10:8] !== 3'b000) begin
            errors++; $display("FAIL frame_w1c got %b required 000", d[10:8]);
        end
        bus_write(5'd3, 32'd0, 4'b0001);
    endtask

    task automatic test_tx_overflow;
        logic [31:0] d;
        logic [1:0]  r;
        data_tx_ack = 1'b0;
        for (int i = 0; i <= DEPTH; i++) bus_write(5'd0, 32'(8'h60 + i), 4'b0001);
        bus_read(5'd1, d, r);
        checks++; if (d[10] !== 1'b1 || d[31:24] !== 8'(DEPTH) || d[0] !== 1'b1) begin
            errors++; $display("FAIL tx_ovf_status got %h required ovf=1 full level %0d", d, DEPTH);
        end
        bus_write(5'd2, 32'h0001_0000, 4'b0100);
        checks++; if (data_tx_wr !== 1'b0) begin
            errors++; $display("FAIL tx_flush_valid got %b required 0", data_tx_wr);
        end
        bus_read(5'd1, d, r);
        checks++; if (d[31:24] !== 8'd0) begin
            errors++; $display("FAIL tx_flush_level got %0d required 0", d[31:24]);
        end
        bus_read(5'd2, d, r);
        checks++; if (d !== 32'h0000_0036) begin
            errors++; $display("FAIL flush_ctrl_read got %h required 00000036", d);
        end
        bus_write(5'd1, 32'h400, 4'b0010);
        bus_read(5'd1, d, r);
        checks++; if (d[10] !== 1'b0) begin
            errors++; $display("FAIL tx_ovf_w1c got %b required 0", d[10]);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); data_rx = 8'hA1; data_rx_ready = 1'b1;
        @(negedge clk); data_rx = 8'hA2;
        @(negedge clk); data_rx_ready = 1'b0; addr = 5'd0; read = 1'b1;
        #1;
        checks++; if (waitreq !== 1'b1) begin
            errors++; $display("FAIL b2b_wait0 got %b required 1", waitreq);
        end
        @(negedge clk);
        checks++; if (waitreq !== 1'b0 || readdata !== 32'hA1) begin
            errors++; $display("FAIL b2b_first got %b/%h required 0/000000a1", waitreq, readdata);
        end
        @(negedge clk);
        checks++; if (waitreq !== 1'b1) begin
            errors++; $display("FAIL b2b_wait1 got %b required 1", waitreq);
        end
        @(negedge clk);
        checks++; if (waitreq !== 1'b0 || readdata !== 32'hA2) begin
            errors++; $display("FAIL b2b_second got %b/%h required 0/000000a2", waitreq, readdata);
        end
        read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] d, exp;
        logic [1:0]  r;
        logic [DW-1:0] v;
        logic        wr;
        bus_write(5'd2, 32'h0003_0000, 4'b0100);
        bus_write(5'd1, 32'h0000_0700, 4'b0010);
        txq.delete(); rxq.delete(); ovf_m = 1'b0;
        @(negedge clk);
        for (int it = 0; it < 400; it++) begin
            checks++; if (data_tx_wr !== (txq.size() != 0)) begin
                errors++; $display("FAIL rnd_tx_valid it=%0d got %b required %b", it, data_tx_wr, txq.size() != 0);
            end
            if (txq.size() != 0) begin
                checks++; if (data_tx !== txq[0]) begin
                    errors++; $display("FAIL rnd_tx_data it=%0d got %h required %h", it, data_tx, txq[0]);
                end
            end
            checks++; if (data_rx_ack !== (rxq.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_rx_ack it=%0d got %b required %b", it, data_rx_ack, rxq.size() < DEPTH);
            end
            if ($urandom_range(0, 7) == 0) begin
                data_tx_ack = 1'b0; data_rx_ready = 1'b0;
                exp = (rxq.size() == 0) ? 32'h8000_0000 : {24'd0, rxq.pop_front()};
                bus_read(5'd0, d, r);
                checks++; if (d !== exp) begin
                    errors++; $display("FAIL rnd_rx_read it=%0d got %h required %h", it, d, exp);
                end
                @(negedge clk);
            end else begin
                data_tx_ack   = 1'($urandom_range(0, 1));
                data_rx_ready = ($urandom_range(0, 2) == 0);
                data_rx       = DW'($urandom);
                wr            = ($urandom_range(0, 2) == 0);
                v             = DW'($urandom);
                if (wr) begin
                    addr = 5'd0; be = 4'b0001; wdata = {24'd0, v}; write = 1'b1;
                end
                if (data_tx_ack && txq.size() != 0) void'(txq.pop_front());
                if (wr) begin
                    if (txq.size() < DEPTH) txq.push_back(v);
                    else ovf_m = 1'b1;
                end
                if (data_rx_ready && rxq.size() < DEPTH) rxq.push_back(data_rx);
                @(negedge clk);
                write = 1'b0; be = 4'd0; data_rx_ready = 1'b0;
            end
        end
        data_tx_ack = 1'b0; data_rx_ready = 1'b0;
        bus_read(5'd1, d, r);
        checks++; if (d[31:24] !== 8'(txq.size()) || d[23:16] !== 8'(rxq.size()) || d[10] !== ovf_m) begin
            errors++; $display("FAIL rnd_status got %h required tx=%0d rx=%0d ovf=%b", d, txq.size(), rxq.size(), ovf_m);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_order();
        test_rx_fill();
        test_thresh_irq();
        test_frame_err();
        test_tx_overflow();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
